tile_column_streamer: RTL and testbench
=======================================

# tile_column_streamer

Streams tiles out as columns, the inverse of the tile-assembly stage: it accepts one complete processed tile per handshake and emits its columns one per cycle toward the per-core column consumers. Each column is tagged with its index, a last flag and the two-half lane mask used by the tile buffers. It sits between the tile producer and the core column inputs, and supports back-to-back tiles with no bubble.

## Interface
- SIZE_OF_EACH_CORE_INPUT, 2, core output side length
- SIZE_OF_EACH_KERNEL, 3, kernel side length
- STRIDE, 1, convolution stride
- PIX_WIDTH, 16, bits per pixel component
- NON_OVERLAPPED_CONST, SIZE_OF_EACH_CORE_INPUT*STRIDE, derived
- SIZE_OF_PRSC_INPUT, STRIDE*(SIZE_OF_EACH_CORE_INPUT-1)+SIZE_OF_EACH_KERNEL, derived (4)
- SIZE_OF_PRSC_OUTPUT (N), 2*SIZE_OF_PRSC_INPUT-(SIZE_OF_PRSC_INPUT-NON_OVERLAPPED_CONST), derived (6)
- Column width CW = N*2*PIX_WIDTH (192 bits at defaults); tile width = N*CW (1152 bits)

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset; synchronous, active-high
- flush_i  in  1  synchronous drop of the tile in flight
- tile_valid_i  in  1  tile_i holds a valid tile
- tile_ready_o  out  1  streamer accepts a tile this cycle
- tile_i  in  N*CW  tile; column k = tile_i[k*CW +: CW]
- col_valid_o  out  1  col_data_o valid
- col_ready_i  in  1  consumer accepts the column
- col_data_o  out  CW  current column
- col_idx_o  out  $clog2(N)  current column index
- col_last_o  out  1  col_idx_o == N-1
- col_lane_o  out  4  4'b0101 if col_idx_o < N/2, else 4'b1010
- tile_cnt_o  out  16  completed tiles, wraps at 2^16

## Operation
- States: IDLE, STREAM.
- IDLE: tile_ready_o=1; on tile_valid_i, register the tile, set idx=0, go to STREAM.
- STREAM: col_valid_o=1. The column handshake is col_valid_o & col_ready_i.
  - Handshake with idx<N-1: idx increments.
  - Handshake with idx==N-1: tile_cnt_o increments.
    - If tile_valid_i is also high, load the new tile, idx=0, stay in STREAM.
    - Otherwise go to IDLE.
- tile_ready_o = (state==IDLE) | (col_valid_o & col_ready_i & col_last_o) & !flush_i. This is a combinational path from col_ready_i.
- Stall: while col_valid_o & !col_ready_i, col_data_o, col_idx_o, col_last_o and col_lane_o hold stable.
- col_data_o is selected from the registered tile by idx. The outputs are zero when col_valid_o=0.
- flush_i (any state): next cycle the state is IDLE, idx=0, and the tile is discarded.
  - tile_cnt_o does not increment, even if flush_i coincides with the last handshake.
  - No tile is accepted that cycle.
- Odd N: the lane split is at idx < N/2 (integer division).

## Timing
- Reset values: tile_ready_o=1 (IDLE), col_valid_o=0, col_data_o=0, col_idx_o=0, col_last_o=0, col_lane_o=0, tile_cnt_o=0.
- Latency: tile accepted at edge t, column 0 valid during cycle t+1.
- Throughput: one column per cycle with col_ready_i held high. N cycles per tile; zero-bubble back-to-back.
- Reset or flush mid-stream: the partial tile is lost; the next tile restarts at column 0.
- rst_i has priority over flush_i, and flush_i has priority over handshakes.
- tile_cnt_o wraps from 16'hFFFF to 0.

## Structure
- The shared package tilling_pkg holds:
  - the derived size functions (PRSC input/output, CW);
  - lane-mask constants LANE_LO=4'b0101 and LANE_HI=4'b1010;
  - the state enum.
- Sub-module tile_column_mux: parameterised N-to-1 CW-bit column select by index, purely combinational. Everything else stays in the top.

## Test plan
- Reset, then one tile with col_ready_i=1, tile columns k = {CW/16{16'h0k0k}}:
  - 6 columns idx 0..5 on consecutive cycles, starting one cycle after acceptance;
  - col_lane_o 0101,0101,0101,1010,1010,1010;
  - col_last_o only at idx 5;
  - tile_cnt_o=1.
- Back-to-back: two tiles, tile_valid_i held high → 12 consecutive valid columns, tile_ready_o pulses on the idx-5 handshake, tile_cnt_o=2.
- Backpressure: col_ready_i=0 for 3 cycles at idx 2 → idx 2 data held unchanged and no advance; completes in 9 cycles.
- Flush at idx 3 → next cycle IDLE, col_valid_o=0, tile_cnt_o unchanged; the following tile streams from idx 0.
- Flush coincident with the last handshake while tile_valid_i=1 → tile not accepted, tile_cnt_o unchanged.
- rst_i at idx 4 → all outputs at reset values next cycle; preload tile_cnt_o near 16'hFFFF via repeated tiles and check the wrap to 0.

Source files
------------

// File: rtl/tilling_pkg.sv
// Shared tile geometry helpers, lane masks and streamer state encoding.
package tilling_pkg;

    localparam logic [3:0] LANE_LO = 4'b0101;
    localparam logic [3:0] LANE_HI = 4'b1010;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    function automatic int prsc_input_size(int core, int kernel, int stride);
        return stride * (core - 1) + kernel;
    endfunction

    // Side length of an assembled tile: one input footprint plus the non-overlapped shift.
    function automatic int prsc_output_size(int core, int kernel, int stride);
        int p;
        p = prsc_input_size(core, kernel, stride);
        return 2 * p - (p - core * stride);
    endfunction

    function automatic int col_width(int n, int pix);
        return n * 2 * pix;
    endfunction

endpackage

// File: rtl/tile_column_streamer_if.sv
// Tile input handshake and column output stream of the tile column streamer.
interface tile_column_streamer_if #(
    parameter int N  = 6,
    parameter int CW = 192
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic              tile_valid_i;
    logic              tile_ready_o;
    logic [N*CW-1:0]   tile_i;
    logic              col_valid_o;
    logic              col_ready_i;
    logic [CW-1:0]     col_data_o;
    logic [IDX_W-1:0]  col_idx_o;
    logic              col_last_o;
    logic [3:0]        col_lane_o;
    logic [15:0]       tile_cnt_o;

    modport master (
        input  tile_valid_i, tile_i, col_ready_i,
        output tile_ready_o, col_valid_o, col_data_o, col_idx_o,
               col_last_o, col_lane_o, tile_cnt_o
    );

    modport slave (
        output tile_valid_i, tile_i, col_ready_i,
        input  tile_ready_o, col_valid_o, col_data_o, col_idx_o,
               col_last_o, col_lane_o, tile_cnt_o
    );

endinterface

// File: rtl/tile_column_mux.sv
// Combinational N-to-1 column select out of a flattened tile.
module tile_column_mux #(
    parameter int N     = 6,
    parameter int CW    = 192,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N*CW-1:0]  tile,
    input  logic [IDX_W-1:0] idx,
    output logic [CW-1:0]    col
);

    always_comb begin
        col = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == IDX_W'(k)) begin
                col = tile[k*CW +: CW];
            end
        end
    end

endmodule

// File: rtl/tile_column_streamer.sv
// Accepts whole tiles and replays them one column per cycle with index,
// last flag and lane mask; back-to-back tiles stream without a bubble.
module tile_column_streamer
    import tilling_pkg::*;
#(
    parameter int SIZE_OF_EACH_CORE_INPUT = 2,
    parameter int SIZE_OF_EACH_KERNEL     = 3,
    parameter int STRIDE                  = 1,
    parameter int PIX_WIDTH               = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    tile_column_streamer_if.master bus
);

    localparam int N     = prsc_output_size(SIZE_OF_EACH_CORE_INPUT, SIZE_OF_EACH_KERNEL, STRIDE);
    localparam int CW    = col_width(N, PIX_WIDTH);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [15:0]      done_cnt;
    logic [N*CW-1:0]  tile_q;
    logic [CW-1:0]    col_sel;
    logic             streaming;
    logic             last_col;
    logic             col_hs;
    logic             accept;

    assign streaming = (state == STREAM);
    assign last_col  = (idx == IDX_W'(N - 1));
    assign col_hs    = streaming & bus.col_ready_i;

    // Ready follows the last-column handshake combinationally so the next tile loads with no gap.
    assign bus.tile_ready_o = (!streaming | (col_hs & last_col)) & !flush_i;
    assign accept           = bus.tile_ready_o & bus.tile_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            idx      <= '0;
            done_cnt <= '0;
        end else if (flush_i) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (accept) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (col_hs) begin
                        if (last_col) begin
                            done_cnt <= done_cnt + 16'd1;
                            idx      <= '0;
                            if (!bus.tile_valid_i) begin
                                state <= IDLE;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && !rst_i) begin
            tile_q <= bus.tile_i;
        end
    end

    tile_column_mux #(
        .N    (N),
        .CW   (CW),
        .IDX_W(IDX_W)
    ) u_mux (
        .tile(tile_q),
        .idx (idx),
        .col (col_sel)
    );

    assign bus.col_valid_o = streaming;
    assign bus.col_data_o  = streaming ? col_sel : '0;
    assign bus.col_idx_o   = streaming ? idx : '0;
    assign bus.col_last_o  = streaming & last_col;
    assign bus.col_lane_o  = !streaming ? 4'b0000 :
                             (idx < IDX_W'(N / 2)) ? LANE_LO : LANE_HI;
    assign bus.tile_cnt_o  = done_cnt;

endmodule

// File: tb/tb_tile_column_streamer.sv
// Bench for tile_column_streamer: directed scenarios plus random traffic against a tile/queue model.
module tb_tile_column_streamer;
    import tilling_pkg::*;

    localparam int N     = prsc_output_size(2, 3, 1);
    localparam int CW    = col_width(N, 16);
    localparam int IDX_W = $clog2(N);

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    tile_column_streamer_if #(.N(N), .CW(CW)) bus ();

    tile_column_streamer dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .flush_i(flush),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [CW-1:0] act, logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the tile as an array of columns, a read position and a completed-tile count.
    bit            m_active;
    int            m_pos;
    logic [15:0]   m_cnt;
    logic [CW-1:0] m_cols [N];
    bit            take_col, fin_tile, acc_tile;
    bit            chk_en = 1'b0;
    bit            preload_req = 1'b0;

    always @(posedge clk) begin
        take_col = m_active && bus.col_ready_i;
        fin_tile = take_col && (m_pos == N - 1);
        acc_tile = (!m_active || fin_tile) && bus.tile_valid_i;
        if (rst) begin
            m_active = 1'b0;
            m_pos    = 0;
            m_cnt    = 16'h0000;
        end else if (preload_req) begin
            m_cnt = 16'hFFFE;
        end else if (flush) begin
            m_active = 1'b0;
            m_pos    = 0;
        end else begin
            if (take_col) m_pos++;
            if (fin_tile) begin
                m_cnt    = m_cnt + 16'd1;
                m_active = 1'b0;
            end
            if (acc_tile) begin
                for (int k = 0; k < N; k++) m_cols[k] = bus.tile_i[k*CW +: CW];
                m_pos    = 0;
                m_active = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0] exp_lane;
            exp_lane = !m_active ? 4'b0000 : (m_pos < N / 2) ? 4'b0101 : 4'b1010;
            check("col_valid", bus.col_valid_o, m_active);
            check("col_idx", bus.col_idx_o, m_active ? m_pos : 0);
            check("col_data", bus.col_data_o, m_active ? m_cols[m_pos] : '0);
            check("col_last", bus.col_last_o, m_active && (m_pos == N - 1));
            check("col_lane", bus.col_lane_o, exp_lane);
            check("tile_cnt", bus.tile_cnt_o, m_cnt);
            check("tile_ready", bus.tile_ready_o,
                  (!m_active || (bus.col_ready_i && m_pos == N - 1)) && !flush);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_tile(output logic [N*CW-1:0] t);
        for (int i = 0; i < N * CW / 32; i++) t[i*32 +: 32] = $urandom;
    endtask

    logic [N*CW-1:0] ta, tb_, tc;
    logic [3:0]      lane_lit [6] = '{4'b0101, 4'b0101, 4'b0101, 4'b1010, 4'b1010, 4'b1010};
    int              cyc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.tile_valid_i = 1'b0;
        bus.col_ready_i = 1'b0;
        bus.tile_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst_valid", bus.col_valid_o, 0);
        check("rst_data", bus.col_data_o, 0);
        check("rst_lane", bus.col_lane_o, 0);
        check("rst_cnt", bus.tile_cnt_o, 0);
        check("rst_ready", bus.tile_ready_o, 1);

        // Single patterned tile, column k = {12{16'h0k0k}}
        for (int k = 0; k < N; k++) begin
            logic [15:0] w;
            w = {4'h0, 4'(k), 4'h0, 4'(k)};
            ta[k*CW +: CW] = {(CW/16){w}};
        end
        bus.tile_i = ta;
        bus.tile_valid_i = 1'b1;
        bus.col_ready_i = 1'b1;
        step();
        bus.tile_valid_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            logic [15:0] m;
            m = 16'h0101 * k;
            @(negedge clk);
            check("t1_valid", bus.col_valid_o, 1);
            check("t1_idx", bus.col_idx_o, k);
            check("t1_lane", bus.col_lane_o, lane_lit[k]);
            check("t1_last", bus.col_last_o, (k == 5));
            check("t1_data", bus.col_data_o, {(CW/16){m}});
            step();
        end
        @(negedge clk);
        check("t1_idle", bus.col_valid_o, 0);
        check("t1_cnt", bus.tile_cnt_o, 1);

        // Back-to-back tiles
        rand_tile(ta);
        rand_tile(tb_);
        bus.tile_i = ta;
        bus.tile_valid_i = 1'b1;
        step();
        bus.tile_i = tb_;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("b2b_valid", bus.col_valid_o, 1);
            if (c == 4) check("b2b_ready_mid", bus.tile_ready_o, 0);
            if (c == 5) check("b2b_ready_last", bus.tile_ready_o, 1);
            if (c == 6) check("b2b_second_col0", bus.col_data_o, tb_[0 +: CW]);
            step();
            if (c == 5) bus.tile_valid_i = 1'b0;
        end
        @(negedge clk);
        check("b2b_idle", bus.col_valid_o, 0);
        check("b2b_cnt", bus.tile_cnt_o, 3);

        // Backpressure: three stalled cycles on column 2
        rand_tile(ta);
        bus.tile_i = ta;
        bus.tile_valid_i = 1'b1;
        step();
        bus.tile_valid_i = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.col_valid_o) break;
            cyc++;
            if (cyc >= 3 && cyc <= 6) begin
                check("bp_idx", bus.col_idx_o, 2);
                check("bp_data", bus.col_data_o, ta[2*CW +: CW]);
            end
            step();
            bus.col_ready_i = !(cyc >= 2 && cyc <= 4);
        end
        check("bp_cycles", cyc, 9);
        bus.col_ready_i = 1'b1;

        // Flush at column 3
        rand_tile(ta);
        bus.tile_i = ta;
        bus.tile_valid_i = 1'b1;
        step();
        bus.tile_valid_i = 1'b0;
        repeat (3) step();
        flush = 1'b1;
        @(negedge clk);
        check("fl_idx", bus.col_idx_o, 3);
        check("fl_ready", bus.tile_ready_o, 0);
        step();
        flush = 1'b0;
        @(negedge clk);
        check("fl_idle", bus.col_valid_o, 0);
        check("fl_cnt", bus.tile_cnt_o, 4);
        rand_tile(tc);
        bus.tile_i = tc;
        bus.tile_valid_i = 1'b1;
        step();
        bus.tile_valid_i = 1'b0;
        @(negedge clk);
        check("fl_restart_idx", bus.col_idx_o, 0);
        check("fl_restart_data", bus.col_data_o, tc[0 +: CW]);
        repeat (6) step();

        // Flush on the last handshake with a new tile offered
        rand_tile(ta);
        bus.tile_i = ta;
        bus.tile_valid_i = 1'b1;
        step();
        bus.tile_valid_i = 1'b0;
        repeat (5) step();
        flush = 1'b1;
        rand_tile(tb_);
        bus.tile_i = tb_;
        bus.tile_valid_i = 1'b1;
        @(negedge clk);
        check("fl_last_flag", bus.col_last_o, 1);
        check("fl_last_ready", bus.tile_ready_o, 0);
        step();
        flush = 1'b0;
        bus.tile_valid_i = 1'b0;
        @(negedge clk);
        check("fl_last_idle", bus.col_valid_o, 0);
        check("fl_last_cnt", bus.tile_cnt_o, 5);

        // Reset at column 4
        rand_tile(ta);
        bus.tile_i = ta;
        bus.tile_valid_i = 1'b1;
        step();
        bus.tile_valid_i = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mr_valid", bus.col_valid_o, 0);
        check("mr_data", bus.col_data_o, 0);
        check("mr_idx", bus.col_idx_o, 0);
        check("mr_last", bus.col_last_o, 0);
        check("mr_lane", bus.col_lane_o, 0);
        check("mr_cnt", bus.tile_cnt_o, 0);
        check("mr_ready", bus.tile_ready_o, 1);

        // Counter wrap: jump close to the top, then finish two tiles
        chk_en = 1'b0;
        force dut.done_cnt = 16'hFFFE;
        preload_req = 1'b1;
        step();
        release dut.done_cnt;
        preload_req = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("wrap_pre", bus.tile_cnt_o, 16'hFFFE);
        rand_tile(ta);
        rand_tile(tb_);
        bus.tile_i = ta;
        bus.tile_valid_i = 1'b1;
        step();
        bus.tile_i = tb_;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 6) check("wrap_ffff", bus.tile_cnt_o, 16'hFFFF);
            step();
            if (c == 5) bus.tile_valid_i = 1'b0;
        end
        @(negedge clk);
        check("wrap_zero", bus.tile_cnt_o, 16'h0000);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 39) == 0);
            bus.col_ready_i = ($urandom_range(0, 3) != 0);
            bus.tile_valid_i = ($urandom_range(0, 2) != 0);
            if (bus.tile_valid_i) begin
                rand_tile(ta);
                bus.tile_i = ta;
            end
            step();
        end
        rst = 1'b0;
        flush = 1'b0;
        bus.tile_valid_i = 1'b0;
        bus.col_ready_i = 1'b1;
        repeat (8) step();

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
